// File: rtl/display_pkg.sv
// Shared display constants and types for the binary-to-BCD converter and its neighbours.
// Holds the digit count, saturation limit, double-dabble iteration count, FSM states and BCD word type.
package display_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int DISP_MAX   = 9999;
    localparam int DD_ITER    = 14;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit k set when digit k and every digit above it are zero; the units digit is never blanked.
    function automatic logic [BCD_DIGITS-1:0] lead_zero_mask(input bcd_t v);
        logic [BCD_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (v[4*k +: 4] == 4'd0);
            m[k]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Bus between the display register (master) and the bin2bcd_seq converter (slave).
// Optional blank_o is present only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if
    import display_pkg::*;
#(
    parameter int IN_W = 32
) ();

    // Handshake: a request is start=1 with bin_i valid; it is taken on the first clock edge
    // where busy=0, otherwise dropped (no queuing). done pulses for one cycle when the
    // result outputs update, and bcd_o/ovf_o then hold until the next done.
    logic            start;
    logic [IN_W-1:0] bin_i;
    logic            busy;
    logic            done;
    bcd_t            bcd_o;
    logic            ovf_o;
    state_t          dbg_state;
`ifdef BIN2BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_o;

    modport master (
        output start, bin_i,
        input  busy, done, bcd_o, ovf_o, dbg_state, blank_o
    );

    modport slave (
        input  start, bin_i,
        output busy, done, bcd_o, ovf_o, dbg_state, blank_o
    );
`else
    modport master (
        output start, bin_i,
        input  busy, done, bcd_o, ovf_o, dbg_state
    );

    modport slave (
        input  start, bin_i,
        output busy, done, bcd_o, ovf_o, dbg_state
    );
`endif

endinterface

// File: rtl/bin2bcd_seq_dd_adj3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more before the next left shift.
module dd_adj3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential saturating binary-to-4-digit-BCD converter (double dabble, 15-cycle latency).
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blanking output blank_o.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int                CNT_W  = $clog2(DD_ITER + 1);
    localparam logic [IN_W-1:0]   MAX_IN = IN_W'(DISP_MAX);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DD_ITER-1:0] r_sat;
    bcd_t               r_scratch;
    logic               r_ovf_next;
    bcd_t               r_bcd;
    logic               r_ovf;
    bcd_t               w_adj;
    logic               w_over;
    logic [DD_ITER-1:0] w_sat_in;
`ifdef BIN2BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] r_blank;
`endif

    // Values above DISP_MAX clamp to it, so the 14-bit shift register always suffices.
    assign w_over   = (bus.bin_i > MAX_IN);
    assign w_sat_in = w_over ? DD_ITER'(DISP_MAX) : bus.bin_i[DD_ITER-1:0];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        dd_adj3 u_adj (
            .i_nib (r_scratch[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // SHIFT lingers one cycle at count 0 so the result lands on the edge entering DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == '0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state != IDLE);
        bus.done      = (r_state == DONE);
        bus.dbg_state = r_state;
        bus.bcd_o     = r_bcd;
        bus.ovf_o     = r_ovf;
`ifdef BIN2BCD_BLANK_EN
        bus.blank_o   = r_blank;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_sat      <= '0;
            r_scratch  <= '0;
            r_ovf_next <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            r_blank    <= 4'b1110;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sat      <= w_sat_in;
                        r_ovf_next <= w_over;
                        r_scratch  <= '0;
                        r_cnt      <= CNT_W'(DD_ITER);
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_scratch <= {w_adj[BCD_W-2:0], r_sat[DD_ITER-1]};
                        r_sat     <= {r_sat[DD_ITER-2:0], 1'b0};
                        r_cnt     <= r_cnt - 1'b1;
                    end else begin
                        r_bcd     <= r_scratch;
                        r_ovf     <= r_ovf_next;
`ifdef BIN2BCD_BLANK_EN
                        r_blank   <= lead_zero_mask(r_scratch);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, multi-cycle corner sequences, random values.
module tb_bin2bcd_seq;
  import display_pkg::*;

  localparam int IN_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: clamp, then split into decimal digits with plain arithmetic.
  // Packed as {ovf, blank[3:0], bcd[15:0]}.
  function automatic logic [20:0] model(input logic [31:0] v);
    int unsigned s;
    logic [15:0] b;
    logic [3:0]  bl;
    s  = (v > 32'd9999) ? 9999 : v;
    b  = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    bl = {s < 1000, s < 100, s < 10, 1'b0};
    return {v > 32'd9999, bl, b};
  endfunction

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  logic [15:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;
  bit          mon_en = 1'b0;
  logic        nib_ok;
  logic [20:0] mon_e;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rst) begin
        hold_bcd = '0;
        hold_ovf = 1'b0;
      end else begin
        nib_ok = 1'b1;
        for (int k = 0; k < 4; k++) if (bus.bcd_o[4*k +: 4] > 4'd9) nib_ok = 1'b0;
        check("nibble_le9", 32'(nib_ok), 32'd1);
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, required no done (queue empty, t=%0t)", $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("bcd_o", 32'(bus.bcd_o), 32'(mon_e[15:0]));
            check("ovf_o", 32'(bus.ovf_o), 32'(mon_e[20]));
`ifdef BIN2BCD_BLANK_EN
            check("blank_o", 32'(bus.blank_o), 32'(mon_e[19:16]));
`endif
            hold_bcd = mon_e[15:0];
            hold_ovf = mon_e[20];
          end
        end else begin
          check("bcd_hold", 32'(bus.bcd_o), 32'(hold_bcd));
          check("ovf_hold", 32'(bus.ovf_o), 32'(hold_ovf));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 32'(lat), 32'd15);
  endtask

  task automatic convert(input logic [31:0] v, input logic [20:0] e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin_i = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin_i = $urandom;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done("latency");
    @(posedge clk);
    #1;
    check("busy_low_after_done", 32'(bus.busy), 32'd0);
    check("done_single_cycle", 32'(bus.done), 32'd0);
  endtask

  typedef struct {
    logic [31:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    int busy_drop;
    int done_seen;
    logic [31:0] v;

    bus.start = 1'b0;
    bus.bin_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd_o), 32'd0);
    check("rst_ovf", 32'(bus.ovf_o), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank", 32'(bus.blank_o), 32'b1110);
`endif
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    vecs[0] = '{32'd1234,       16'h1234, 1'b0, 4'b0000};
    vecs[1] = '{32'd9999,       16'h9999, 1'b0, 4'b0000};
    vecs[2] = '{32'h0001_0000,  16'h9999, 1'b1, 4'b0000};
    vecs[3] = '{32'd10,         16'h0010, 1'b0, 4'b1100};
    vecs[4] = '{32'd0,          16'h0000, 1'b0, 4'b1110};
    vecs[5] = '{32'd100,        16'h0100, 1'b0, 4'b1000};
    vecs[6] = '{32'd10000,      16'h9999, 1'b1, 4'b0000};
    vecs[7] = '{32'hFFFF_FFFF,  16'h9999, 1'b1, 4'b0000};
    vecs[8] = '{32'd9,          16'h0009, 1'b0, 4'b1110};
    vecs[9] = '{32'd1000,       16'h1000, 1'b0, 4'b0000};

    for (int i = 0; i < 10; i++)
      convert(vecs[i].bin, {vecs[i].ovf, vecs[i].blank, vecs[i].bcd});

    // start held high across a whole conversion; bin_i switches mid-flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin_i = 32'd3725;
    exp_q.push_back({1'b0, 4'b0000, 16'h3725});
    exp_q.push_back({1'b0, 4'b1100, 16'h0042});
    @(posedge clk);
    #1;
    busy_drop = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 5) bus.bin_i = 32'd42;
      if (!bus.busy) busy_drop++;
      @(posedge clk);
      #1;
    end
    check("held_done_at_15", 32'(bus.done), 32'd1);
    check("held_busy_continuous", 32'(busy_drop), 32'd0);
    @(posedge clk);
    #1;
    check("held_idle_gap", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("held_back_to_back", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("held_second_latency");
    @(posedge clk);
    #1;

    // reset during a conversion aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin_i = 32'd1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.bcd_o), 32'd0);
    check("abort_ovf", 32'(bus.ovf_o), 32'd0);
    check("abort_state", 32'(bus.dbg_state), 32'(IDLE));
`ifdef BIN2BCD_BLANK_EN
    check("abort_blank", 32'(bus.blank_o), 32'b1110);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("no_done_after_abort", 32'(done_seen), 32'd0);
    convert(32'd58, {1'b0, 4'b1100, 16'h0058});

    // random values against the arithmetic reference
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom;
      else v = 32'($urandom_range(0, 12000));
      convert(v, model(v));
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
